// File: rtl/rr_mux4_pkg.sv
// Shared types, sizes and the rotating-priority search used by the round-robin mux arbiter.
package rr_mux4_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Index of the first set request found searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [SEL_W-1:0]   ptr);
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] pick;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ptr + SEL_W'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_mux4_arbiter_mux4_w.sv
// WIDTH-bit 4:1 combinational mux carrying the granted requester's data to the shared port.
module mux4_w
    import rr_mux4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [NUM_REQ*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]         sel,
    output logic [WIDTH-1:0]         data_out
);

    always_comb begin
        case (sel)
            2'd0:    data_out = data_in[0*WIDTH +: WIDTH];
            2'd1:    data_out = data_in[1*WIDTH +: WIDTH];
            2'd2:    data_out = data_in[2*WIDTH +: WIDTH];
            default: data_out = data_in[3*WIDTH +: WIDTH];
        endcase
    end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter granting one of four requesters a burst on a shared valid/ready port.
module rr_mux4_arbiter
    import rr_mux4_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       last,
    input  logic [NUM_REQ*WIDTH-1:0] data_in,
    output logic [NUM_REQ-1:0]       in_ready,
    output logic [NUM_REQ-1:0]       grant,
    output logic [SEL_W-1:0]         sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_last
);

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BEATS - 1);

    state_t             state_q,    state_d;
    logic [NUM_REQ-1:0] grant_q,    grant_d;
    logic [SEL_W-1:0]   sel_q,      sel_d;
    logic [SEL_W-1:0]   ptr_q,      ptr_d;
    logic [7:0]         beat_cnt_q, beat_cnt_d;

    logic [SEL_W-1:0]   pick;
    logic               xfer;
    logic               rel;

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign out_valid = (state_q == BUSY) & req[sel_q];
    assign in_ready  = grant_q & {NUM_REQ{out_ready}};
    assign out_last  = last[sel_q] & out_valid;
    assign xfer      = out_valid & out_ready;
    assign pick      = rr_pick(req, ptr_q);

    mux4_w #(.WIDTH(WIDTH)) u_data_mux (
        .data_in  (data_in),
        .sel      (sel_q),
        .data_out (out_data)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        rel        = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d       = BUSY;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    sel_d         = pick;
                    beat_cnt_d    = '0;
                end
            end
            BUSY: begin
                // A withdrawn request releases without a transfer; a stall neither counts nor releases.
                if (!req[sel_q]) begin
                    rel = 1'b1;
                end else if (xfer) begin
                    if (last[sel_q] || (beat_cnt_q == LAST_BEAT)) begin
                        rel = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
                if (rel) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    ptr_d      = sel_q;
                    beat_cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Pointer resets to 3 so requester 0 has first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            sel_q      <= '0;
            ptr_q      <= 2'd3;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench for rr_mux4_arbiter: a cycle table plus hand-written burst, stall and reset sequences.
module tb_rr_mux4_arbiter;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req;
    logic [3:0]       last;
    logic [4*WIDTH-1:0] data_in;
    logic [3:0]       in_ready;
    logic [3:0]       grant;
    logic [1:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    int n_checks = 0;
    int n_fail   = 0;

    rr_mux4_arbiter #(.WIDTH(WIDTH), .MAX_BEATS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .data_in   (data_in),
        .in_ready  (in_ready),
        .grant     (grant),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] last;
        logic       rdy;
        logic [3:0] g;
        logic [1:0] s;
        logic       ov;
        logic [3:0] ir;
        logic       ol;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                           input logic ov, input logic [3:0] ir, input logic ol);
        logic [WIDTH-1:0] exp_d;
        exp_d = data_in[s*WIDTH +: WIDTH];
        chk({tag, ".grant"},     32'(grant),     32'(g));
        chk({tag, ".sel"},       32'(sel),       32'(s));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
        chk({tag, ".out_last"},  32'(out_last),  32'(ol));
        chk({tag, ".out_data"},  32'(out_data),  32'(exp_d));
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic rdy);
        @(negedge clk);
        req       = r;
        last      = l;
        out_ready = rdy;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] oh;
        logic [1:0] order [5];

        tbl[0]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0};
        tbl[1]  = '{4'b0001, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0};
        tbl[2]  = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001, 1'b0};
        tbl[3]  = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001, 1'b0};
        tbl[4]  = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001, 1'b1};
        tbl[5]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0};
        tbl[6]  = '{4'b0011, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0};
        tbl[7]  = '{4'b0011, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010, 1'b0};
        tbl[8]  = '{4'b0001, 4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0, 4'b0010, 1'b0};
        tbl[9]  = '{4'b0001, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 4'b0000, 1'b0};
        tbl[10] = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b0, 4'b0001, 1'b0};
        tbl[11] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0};

        data_in   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        rst_n     = 1'b0;
        req       = 4'b0000;
        last      = 4'b0000;
        out_ready = 1'b1;
        #12;
        chk_all("reset", 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-requester burst ending on last, then withdraw cases and pointer advance.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].req, tbl[i].last, tbl[i].rdy);
            chk_all($sformatf("tbl%0d", i), tbl[i].g, tbl[i].s, tbl[i].ov, tbl[i].ir, tbl[i].ol);
        end

        // All four requesting: order 0,1,2,3,0 from reset, 4 beats then one idle cycle each.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int g = 0; g < 5; g++) begin
            drive(4'b1111, 4'b0000, 1'b1);
            chk_all($sformatf("rr%0d.idle", g), 4'b0000, (g == 0) ? 2'd0 : order[g-1],
                    1'b0, 4'b0000, 1'b0);
            oh = 4'b0001 << order[g];
            for (int b = 0; b < 4; b++) begin
                drive(4'b1111, 4'b0000, 1'b1);
                chk_all($sformatf("rr%0d.b%0d", g, b), oh, order[g], 1'b1, oh, 1'b0);
            end
        end

        // Requester 2 sends one beat then withdraws; requester 3 is next.
        drive(4'b1100, 4'b0000, 1'b1);
        chk_all("wd.idle", 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
        drive(4'b1100, 4'b0000, 1'b1);
        chk_all("wd.beat", 4'b0100, 2'd2, 1'b1, 4'b0100, 1'b0);
        drive(4'b1000, 4'b0000, 1'b1);
        chk_all("wd.drop", 4'b0100, 2'd2, 1'b0, 4'b0100, 1'b0);
        drive(4'b1000, 4'b0000, 1'b1);
        chk_all("wd.rel", 4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0);
        drive(4'b1000, 4'b0000, 1'b1);
        chk_all("wd.g3", 4'b1000, 2'd3, 1'b1, 4'b1000, 1'b0);
        drive(4'b0000, 4'b0000, 1'b1);
        chk_all("wd.g3drop", 4'b1000, 2'd3, 1'b0, 4'b1000, 1'b0);

        // Requester 1 stalled 5 cycles, then 4 beats with last coinciding with the beat limit.
        drive(4'b0010, 4'b0000, 1'b0);
        chk_all("st.idle", 4'b0000, 2'd3, 1'b0, 4'b0000, 1'b0);
        for (int c = 0; c < 5; c++) begin
            drive(4'b0010, 4'b0000, 1'b0);
            chk_all($sformatf("st.stall%0d", c), 4'b0010, 2'd1, 1'b1, 4'b0000, 1'b0);
        end
        for (int b = 0; b < 4; b++) begin
            drive(4'b0010, (b == 3) ? 4'b0010 : 4'b0000, 1'b1);
            chk_all($sformatf("st.b%0d", b), 4'b0010, 2'd1, 1'b1, 4'b0010, (b == 3));
        end
        drive(4'b0000, 4'b0000, 1'b1);
        chk_all("st.rel", 4'b0000, 2'd1, 1'b0, 4'b0000, 1'b0);

        // Asynchronous reset mid-burst on requester 3, then requester 0 wins over 3.
        drive(4'b1000, 4'b0000, 1'b1);
        chk_all("rs.idle", 4'b0000, 2'd1, 1'b0, 4'b0000, 1'b0);
        drive(4'b1000, 4'b0000, 1'b1);
        chk_all("rs.b0", 4'b1000, 2'd3, 1'b1, 4'b1000, 1'b0);
        drive(4'b1000, 4'b0000, 1'b1);
        chk_all("rs.b1", 4'b1000, 2'd3, 1'b1, 4'b1000, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all("rs.async", 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
        drive(4'b1001, 4'b0000, 1'b1);
        rst_n = 1'b1;
        #1;
        chk_all("rs.idle2", 4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0);
        drive(4'b1001, 4'b0000, 1'b1);
        chk_all("rs.g0", 4'b0001, 2'd0, 1'b1, 4'b0001, 1'b0);
        drive(4'b0000, 4'b0000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
